acc_store_buffer: RTL
=====================

# acc_store_buffer

Posted-store buffer between the BIP I accumulator and data memory. On a store instruction it captures the accumulator value and its target address into a small FIFO. A request/acknowledge engine then drains the entries to a slow data-memory port, so the CPU stalls only when the buffer is full. It is the consuming end of the accumulator write path: `Acc` produces `AccOut`, and this block reads it out to memory.

## Interface
- `DATA_W`, 16, accumulator/data width
- `ADDR_W`, 11, data-memory address width
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2

- `Clock`  in  1  sole clock; all state updates on rising edge
- `Reset`  in  1  synchronous, active-high reset
- `AccOut`  in  DATA_W  accumulator value to store
- `StAddr`  in  ADDR_W  store target address
- `WrRam`  in  1  store strobe; one entry per cycle high
- `Stall`  out  1  buffer full; CPU must hold `WrRam`/`AccOut`/`StAddr`
- `MemReq`  out  1  memory write request
- `MemAddr`  out  ADDR_W  request address
- `MemData`  out  DATA_W  request data
- `MemAck`  in  1  memory accepted the current request
- `FwdAddr`  in  ADDR_W  load address to check against pending stores
- `FwdHit`  out  1  a pending entry matches `FwdAddr`
- `FwdData`  out  DATA_W  data of the youngest matching entry

## Operation
- FIFO state: `wr_ptr`, `rd_ptr` (log2 DEPTH bits, wrap naturally), `count` (log2(DEPTH+1) bits).
- `Stall` = (`count` == DEPTH), decoded from registers only.
- Push: `WrRam` && !`Stall` writes {`StAddr`, `AccOut`} at `wr_ptr`, then increments `wr_ptr`.
- `WrRam` while `Stall` is set: dropped, with no state change. The CPU re-presents it.
- Drain FSM, states IDLE and REQ:
  - IDLE: if `count` != 0, go to REQ.
  - REQ: `MemReq`=1; `MemAddr`/`MemData` = head entry, held stable until ack.
  - REQ with `MemAck`=1: pop (increment `rd_ptr`), go to IDLE.
- `MemAck` outside REQ is ignored.
- Push and pop in the same cycle: both take effect and `count` is unchanged.
- A push while full is refused even if a pop occurs in that cycle.
- `MemReq` is low in IDLE. `MemAddr`/`MemData` are 0 in IDLE.
- Stores reach memory strictly in program order.

## Timing
- Reset values: `Stall`=0, `MemReq`=0, `MemAddr`=0, `MemData`=0, `FwdHit`=0, `FwdData`=0, FSM=IDLE, pointers and count = 0.
- Reset mid-transaction abandons the request and empties the buffer. `MemReq` is low in the cycle after the reset edge.
- Latency: a push at edge N gives `MemReq`=1 after edge N+1 at the earliest.
- Minimum spacing: one IDLE cycle between requests, so peak drain is 1 store per 2 cycles.
- Each `MemAck` completes exactly one store. Memory may hold `MemAck` low indefinitely.
- `Stall` deasserts the cycle after the pop that frees a slot.

## Configuration
- `ACC_STORE_FWD_EN` defined:
  - `FwdHit`/`FwdData` are combinational over all valid entries.
  - On multiple matches, the youngest entry wins.
  - An entry being pushed in the current cycle is not visible.
  - An entry remains visible until its pop edge.
- Not defined: ports are still present; `FwdHit`=0 and `FwdData`=0 always, and no compare logic is built.

## Structure
- Shared `bip_pkg`: default widths (`DATA_W`, `ADDR_W`), drain-FSM state enum, and an entry struct {addr, data}.
- One natural sub-module, `store_fifo`:
  - Storage array, pointers and count.
  - Exposes the head entry and full/empty.
  - Exposes the entry array for the forwarding compare.
- The drain FSM and forwarding logic live in the top module.

## Test plan
- Single store: `WrRam` with addr 0x005, data 247 → `MemReq`=1 one cycle later with 0x005/247. `MemAck` one cycle later → `MemReq`=0 and buffer empty.
- Fill, with `MemAck` held 0: 4 stores 0x010..0x013 → `Stall`=1 after the 4th. A 5th store of 2222 is dropped until `MemAck` pops one, then accepted the following cycle.
- Order and backpressure: 3 stores with data 1, 2, 3; ack after 0/3/1 wait cycles → memory sees 1, 2, 3 in order, each held stable until acked.
- Simultaneous push/pop at count=2 → count stays 2, and the next request carries the correct next entry.
- Reset mid-REQ with 3 entries → `MemReq`=0 and `Stall`=0 next cycle, no further requests; a later `MemAck` is ignored.
- With `ACC_STORE_FWD_EN`: stores 0x020=7 then 0x020=9 pending, `FwdAddr`=0x020 → `FwdHit`=1, `FwdData`=9. After both pops, `FwdHit`=0. Without the macro, `FwdHit` is always 0.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared BIP definitions: default datapath widths, drain-FSM states and the
// store-buffer entry layout.
package bip_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 11;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/store_fifo.sv
// Circular store queue: entry storage, wrapping pointers and occupancy count.
// Exposes the head entry plus the whole array for the forwarding compare.
module store_fifo
    import bip_pkg::*;
#(
    parameter int DATA_W = bip_pkg::DATA_W,
    parameter int ADDR_W = bip_pkg::ADDR_W,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [PTR_W-1:0]  rd_ptr,
    output logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] entry_addr [DEPTH],
    output logic [DATA_W-1:0] entry_data [DEPTH]
);

    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push is refused while full even if a pop lands in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_addr = entry_addr[rd_ptr];
    assign head_data = entry_data[rd_ptr];

    always_ff @(posedge Clock) begin
        if (do_push) begin
            entry_addr[wr_ptr] <= push_addr;
            entry_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/acc_store_buffer.sv
// Posted-store buffer from the accumulator to a slow data-memory port, drained
// by a request/acknowledge FSM. Store-to-load forwarding under ACC_STORE_FWD_EN.
module acc_store_buffer
    import bip_pkg::*;
#(
    parameter int DATA_W = bip_pkg::DATA_W,
    parameter int ADDR_W = bip_pkg::ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] AccOut,
    input  logic [ADDR_W-1:0] StAddr,
    input  logic              WrRam,
    output logic              Stall,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemData,
    input  logic              MemAck,
    input  logic [ADDR_W-1:0] FwdAddr,
    output logic              FwdHit,
    output logic [DATA_W-1:0] FwdData,
    output drain_state_e      drain_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    drain_state_e      state;
    drain_state_e      state_next;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] entry_addr [DEPTH];
    logic [DATA_W-1:0] entry_data [DEPTH];

    store_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .Clock      (Clock),
        .Reset      (Reset),
        .push       (WrRam),
        .push_addr  (StAddr),
        .push_data  (AccOut),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .rd_ptr     (rd_ptr),
        .count      (count),
        .entry_addr (entry_addr),
        .entry_data (entry_data)
    );

    assign Stall       = full;
    assign drain_state = state;

    // Memory handshake: MemReq stays high with a stable head entry until MemAck;
    // the ack edge pops exactly one entry and always returns to IDLE for a cycle.
    always_ff @(posedge Clock) begin
        if (Reset) state <= DRAIN_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        MemReq     = 1'b0;
        MemAddr    = '0;
        MemData    = '0;
        case (state)
            DRAIN_IDLE: begin
                if (!empty) state_next = DRAIN_REQ;
            end
            DRAIN_REQ: begin
                MemReq  = 1'b1;
                MemAddr = head_addr;
                MemData = head_data;
                if (MemAck) begin
                    pop        = 1'b1;
                    state_next = DRAIN_IDLE;
                end
            end
            default: state_next = DRAIN_IDLE;
        endcase
    end

`ifdef ACC_STORE_FWD_EN
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        FwdHit  = 1'b0;
        FwdData = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && (entry_addr[idx] == FwdAddr)) begin
                FwdHit  = 1'b1;
                FwdData = entry_data[idx];
            end
        end
    end
`else
    logic unused_fwd;

    assign FwdHit  = 1'b0;
    assign FwdData = '0;

    always_comb begin
        unused_fwd = ^{FwdAddr, rd_ptr, count};
        for (int k = 0; k < DEPTH; k++) begin
            unused_fwd = unused_fwd ^ (^entry_addr[k]) ^ (^entry_data[k]);
        end
    end
`endif

endmodule
